// File: rtl/apb_mem_arbiter_if.sv
// Bundle of requester A/B command ports and the apb_mem control/data lines
// seen by apb_mem_arbiter.
interface apb_mem_arbiter_if #(
  parameter int MEM_WIDTH = 8,
  parameter int MEM_DEPTH = 4,
  parameter int MEM_SIZE  = 256
);
  localparam int ADDR_W = $clog2(MEM_SIZE);
  localparam int DATA_W = MEM_WIDTH * MEM_DEPTH;

  logic              a_req;
  logic              a_wr;
  logic [ADDR_W-1:0] a_addr;
  logic [MEM_DEPTH-1:0] a_be;
  logic [DATA_W-1:0] a_wdata;
  logic              a_done;
  logic [DATA_W-1:0] a_rdata;

  logic              b_req;
  logic              b_wr;
  logic [ADDR_W-1:0] b_addr;
  logic [MEM_DEPTH-1:0] b_be;
  logic [DATA_W-1:0] b_wdata;
  logic              b_done;
  logic [DATA_W-1:0] b_rdata;

  logic              busy;
  logic              gnt_id;

  logic              mem_wr;
  logic              mem_rd;
  logic [MEM_DEPTH-1:0] mem_be;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] mem_data_out;

  modport slave (
    input  a_req, a_wr, a_addr, a_be, a_wdata,
    input  b_req, b_wr, b_addr, b_be, b_wdata,
    input  mem_data_out,
    output a_done, a_rdata, b_done, b_rdata,
    output busy, gnt_id,
    output mem_wr, mem_rd, mem_be, mem_address, mem_data_in
  );

  modport master (
    output a_req, a_wr, a_addr, a_be, a_wdata,
    output b_req, b_wr, b_addr, b_be, b_wdata,
    output mem_data_out,
    input  a_done, a_rdata, b_done, b_rdata,
    input  busy, gnt_id,
    input  mem_wr, mem_rd, mem_be, mem_address, mem_data_in
  );
endinterface

// File: rtl/apb_mem_arbiter.sv
// Round-robin arbiter/sequencer giving requesters A and B single-cycle
// word accesses to the banked memory; IDLE -> ACCESS -> RESP per command.
module apb_mem_arbiter #(
  parameter int MEM_WIDTH = 8,
  parameter int MEM_DEPTH = 4,
  parameter int MEM_SIZE  = 256
) (
  input  logic clk,
  input  logic rst,
  apb_mem_arbiter_if.slave bus
);
  localparam int ADDR_W = $clog2(MEM_SIZE);
  localparam int DATA_W = MEM_WIDTH * MEM_DEPTH;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t               state_q, state_d;
  logic                 mem_wr_q, mem_wr_d;
  logic                 mem_rd_q, mem_rd_d;
  logic [MEM_DEPTH-1:0] mem_be_q, mem_be_d;
  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]    mem_wdata_q, mem_wdata_d;
  logic                 gnt_q, gnt_d;
  logic                 a_done_q, a_done_d;
  logic                 b_done_q, b_done_d;
  logic                 busy_q, busy_d;
  logic [DATA_W-1:0]    a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0]    b_rdata_q, b_rdata_d;
  logic                 win;

  always_comb begin
    state_d     = state_q;
    mem_wr_d    = mem_wr_q;
    mem_rd_d    = mem_rd_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    gnt_d       = gnt_q;
    a_done_d    = 1'b0;
    b_done_d    = 1'b0;
    busy_d      = busy_q;
    a_rdata_d   = a_rdata_q;
    b_rdata_d   = b_rdata_q;
    // On a tie the requester that did not win last time goes next.
    win = (bus.a_req && bus.b_req) ? ~gnt_q : bus.b_req;

    case (state_q)
      IDLE: begin
        mem_wr_d = 1'b0;
        mem_rd_d = 1'b0;
        if (bus.a_req || bus.b_req) begin
          gnt_d       = win;
          mem_wr_d    = win ? bus.b_wr : bus.a_wr;
          mem_rd_d    = win ? ~bus.b_wr : ~bus.a_wr;
          mem_addr_d  = win ? bus.b_addr : bus.a_addr;
          mem_be_d    = win ? bus.b_be : bus.a_be;
          mem_wdata_d = win ? bus.b_wdata : bus.a_wdata;
          busy_d      = 1'b1;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        if (mem_rd_q) begin
          if (gnt_q) b_rdata_d = bus.mem_data_out;
          else       a_rdata_d = bus.mem_data_out;
        end
        mem_wr_d = 1'b0;
        mem_rd_d = 1'b0;
        a_done_d = ~gnt_q;
        b_done_d = gnt_q;
        state_d  = RESP;
      end
      RESP: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        mem_wr_d = 1'b0;
        mem_rd_d = 1'b0;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  // gnt_q resets to B so that A takes the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_wr_q    <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      gnt_q       <= 1'b1;
      a_done_q    <= 1'b0;
      b_done_q    <= 1'b0;
      busy_q      <= 1'b0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      mem_wr_q    <= mem_wr_d;
      mem_rd_q    <= mem_rd_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      gnt_q       <= gnt_d;
      a_done_q    <= a_done_d;
      b_done_q    <= b_done_d;
      busy_q      <= busy_d;
      a_rdata_q   <= a_rdata_d;
      b_rdata_q   <= b_rdata_d;
    end
  end

  // Strobes are masked by reset so an access cut off by reset never reaches the memory.
  assign bus.mem_wr      = mem_wr_q & ~rst;
  assign bus.mem_rd      = mem_rd_q & ~rst;
  assign bus.mem_be      = mem_be_q;
  assign bus.mem_address = mem_addr_q;
  assign bus.mem_data_in = mem_wdata_q;
  assign bus.gnt_id      = gnt_q;
  assign bus.busy        = busy_q;
  assign bus.a_done      = a_done_q;
  assign bus.b_done      = b_done_q;
  assign bus.a_rdata     = a_rdata_q;
  assign bus.b_rdata     = b_rdata_q;
endmodule
